// File: rtl/btog_pkg.sv
// Shared constants and pure helpers for the binary-to-Gray converter.
// bin2gray / gray2bin work on a 32-bit container and take the active width
// as an argument, so every instance of any width 2..32 shares one copy.
package btog_pkg;

   localparam int BTOG_DEFAULT_WIDTH = 4;

   // Mask with the low w bits set (w in 1..32).
   function automatic logic [31:0] width_mask(input int unsigned w);
      logic [31:0] m;
      if (w >= 32'd32) begin
         m = 32'hFFFF_FFFF;
      end else begin
         m = (32'd1 << w) - 32'd1;
      end
      return m;
   endfunction

   // Gray code of b: each bit is the XOR of itself and its upper neighbour.
   function automatic logic [31:0] bin2gray(input logic [31:0] b, input int unsigned w);
      return (b ^ (b >> 1)) & width_mask(w);
   endfunction

   // Binary from Gray: running XOR from the MSB downwards.
   function automatic logic [31:0] gray2bin(input logic [31:0] g, input int unsigned w);
      logic [31:0] gm;
      logic [31:0] b;
      gm = g & width_mask(w);
      b  = 32'd0;
      for (int i = 31; i >= 0; i--) begin
         if (i == 31) begin
            b[i] = gm[i];
         end else begin
            b[i] = b[i+1] ^ gm[i];
         end
      end
      return b;
   endfunction

endpackage

// File: rtl/btog_enc.sv
// Combinational binary-to-Gray encoder, WIDTH bits in and out.
module btog_enc
   import btog_pkg::*;
#(
   parameter int WIDTH = BTOG_DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] bin,
   output logic [WIDTH-1:0] gray
);

   // Pure bitwise conversion; no carry chain, every code is legal.
   always_comb begin
      gray = WIDTH'(bin2gray(32'(bin), WIDTH));
   end

endmodule

// File: rtl/btog_conv_df.sv
// Registered binary-to-Gray converter with a one-cycle valid pipeline.
// Optional self-check path (shadow of accepted bin, Gray decoder, sticky
// err flag and the err port) is compiled in with macro BTOG_CHECK_EN.
module btog_conv_df
   import btog_pkg::*;
#(
   parameter int WIDTH = BTOG_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] bin,
   input  logic             in_valid,
   output logic [WIDTH-1:0] gray,
   output logic             out_valid
`ifdef BTOG_CHECK_EN
   ,
   output logic             err
`endif
);

   logic [WIDTH-1:0] w_gray;
   logic [WIDTH-1:0] r_gray;
   logic             r_valid;

   btog_enc #(
      .WIDTH (WIDTH)
   ) u_enc (
      .bin  (bin),
      .gray (w_gray)
   );

   // Output register: load on accepted input, hold otherwise; reset wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_gray  <= '0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= in_valid;
         if (in_valid) begin
            r_gray <= w_gray;
         end else begin
            r_gray <= r_gray;
         end
      end
   end

   assign gray      = r_gray;
   assign out_valid = r_valid;

`ifdef BTOG_CHECK_EN
   logic [WIDTH-1:0] r_bin;
   logic [WIDTH-1:0] w_dec;
   logic             r_err;

   // Decode the registered Gray value back to binary for comparison.
   always_comb begin
      w_dec = WIDTH'(gray2bin(32'(r_gray), WIDTH));
   end

   // Shadow the accepted bin and latch any round-trip mismatch until reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_bin <= '0;
         r_err <= 1'b0;
      end else begin
         if (in_valid) begin
            r_bin <= bin;
         end else begin
            r_bin <= r_bin;
         end
         if (r_valid && (w_dec != r_bin)) begin
            r_err <= 1'b1;
         end else begin
            r_err <= r_err;
         end
      end
   end

   assign err = r_err;
`endif

endmodule

// File: tb/tb_btog_conv_df.sv
// Self-checking bench for btog_conv_df (WIDTH=4). Expected Gray values come
// from the arithmetic rule gray = b ^ (b / 2) and from the directed table.
module tb_btog_conv_df;

   localparam int W = 4;

   logic         clk;
   logic         rst;
   logic [W-1:0] bin;
   logic         in_valid;
   logic [W-1:0] gray;
   logic         out_valid;
`ifdef BTOG_CHECK_EN
   logic         err;
`endif

   int total;
   int bad;

   btog_conv_df #(
      .WIDTH (W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bin       (bin),
      .in_valid  (in_valid),
      .gray      (gray),
      .out_valid (out_valid)
`ifdef BTOG_CHECK_EN
      ,
      .err       (err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference conversion written as plain arithmetic.
   function automatic logic [W-1:0] ref_gray(input int unsigned b);
      int unsigned v;
      v = b % 16;
      return W'(v ^ (v / 2));
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic v, input logic [W-1:0] b);
      rst      = r;
      in_valid = v;
      bin      = b;
   endtask

   task automatic test_reset();
      drive(1'b1, 1'b1, 4'b1111);
      tick();
      total++;
      if (gray !== 4'b0000) begin
         bad++;
         $display("FAIL reset_gray: got %b want 0000", gray);
      end
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_valid: got %b want 0", out_valid);
      end
`ifdef BTOG_CHECK_EN
      total++;
      if (err !== 1'b0) begin
         bad++;
         $display("FAIL reset_err: got %b want 0", err);
      end
`endif
   endtask

   task automatic test_table();
      logic [W-1:0] tb_in  [10];
      logic [W-1:0] tb_exp [10];
      tb_in  = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
                 4'b0101, 4'b0110, 4'b0111, 4'b1000, 4'b1111};
      tb_exp = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110,
                 4'b0111, 4'b0101, 4'b0100, 4'b1100, 4'b1000};
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, 1'b1, tb_in[i]);
         tick();
         total++;
         if (gray !== tb_exp[i] || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL table[%0d]: bin %b got gray %b valid %b want %b valid 1",
                     i, tb_in[i], gray, out_valid, tb_exp[i]);
         end
      end
   endtask

   task automatic test_hold();
      drive(1'b0, 1'b1, 4'b0101);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 4'b1111);
         tick();
         total++;
         if (gray !== 4'b0111 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL hold[%0d]: got gray %b valid %b want 0111 valid 0",
                     i, gray, out_valid);
         end
      end
   endtask

   task automatic test_sweep();
      logic [W-1:0] prev;
      prev = '0;
      for (int i = 0; i <= 16; i++) begin
         drive(1'b0, 1'b1, W'(i % 16));
         tick();
         total++;
         if (gray !== ref_gray(i)) begin
            bad++;
            $display("FAIL sweep_val[%0d]: got %b want %b", i, gray, ref_gray(i));
         end
         if (i > 0) begin
            total++;
            if ($countones(gray ^ prev) != 1) begin
               bad++;
               $display("FAIL sweep_hamming[%0d]: prev %b now %b distance %0d want 1",
                        i, prev, gray, $countones(gray ^ prev));
            end
         end
         prev = gray;
      end
   endtask

   task automatic test_midreset();
      drive(1'b0, 1'b1, 4'b0110);
      tick();
      total++;
      if (gray !== 4'b0101) begin
         bad++;
         $display("FAIL midrst_pre: got %b want 0101", gray);
      end
      drive(1'b1, 1'b1, 4'b0011);
      tick();
      total++;
      if (gray !== 4'b0000 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL midrst_clear: got gray %b valid %b want 0000 valid 0",
                  gray, out_valid);
      end
      drive(1'b0, 1'b1, 4'b0011);
      tick();
      total++;
      if (gray !== 4'b0010 || out_valid !== 1'b1) begin
         bad++;
         $display("FAIL midrst_post: got gray %b valid %b want 0010 valid 1",
                  gray, out_valid);
      end
   endtask

   task automatic test_random();
      logic [W-1:0] exp_g;
      logic         exp_v;
      logic         r;
      logic         v;
      logic [W-1:0] b;
      drive(1'b1, 1'b0, 4'b0000);
      tick();
      exp_g = '0;
      exp_v = 1'b0;
      for (int i = 0; i < 300; i++) begin
         r = ($urandom_range(0, 19) == 0);
         v = $urandom_range(0, 1) == 1;
         b = W'($urandom_range(0, 15));
         drive(r, v, b);
         tick();
         if (r) begin
            exp_g = '0;
            exp_v = 1'b0;
         end else if (v) begin
            exp_g = ref_gray(b);
            exp_v = 1'b1;
         end else begin
            exp_v = 1'b0;
         end
         total++;
         if (gray !== exp_g || out_valid !== exp_v) begin
            bad++;
            $display("FAIL random[%0d]: got gray %b valid %b want %b valid %b",
                     i, gray, out_valid, exp_g, exp_v);
         end
      end
   endtask

`ifdef BTOG_CHECK_EN
   task automatic test_check();
      drive(1'b1, 1'b0, 4'b0000);
      tick();
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, 1'b1, W'(i));
         tick();
      end
      drive(1'b0, 1'b0, 4'b0000);
      tick();
      tick();
      total++;
      if (err !== 1'b0) begin
         bad++;
         $display("FAIL check_clean: got err %b want 0", err);
      end
      force dut.w_gray = 4'b0000;
      drive(1'b0, 1'b1, 4'b0001);
      tick();
      release dut.w_gray;
      drive(1'b0, 1'b0, 4'b0000);
      tick();
      total++;
      if (err !== 1'b1) begin
         bad++;
         $display("FAIL check_detect: got err %b want 1", err);
      end
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, W'(i + 4));
         tick();
      end
      total++;
      if (err !== 1'b1) begin
         bad++;
         $display("FAIL check_sticky: got err %b want 1", err);
      end
      drive(1'b1, 1'b0, 4'b0000);
      tick();
      total++;
      if (err !== 1'b0) begin
         bad++;
         $display("FAIL check_clear: got err %b want 0", err);
      end
   endtask
`endif

   initial begin
      total = 0;
      bad   = 0;
      drive(1'b1, 1'b0, 4'b0000);
      tick();
      test_reset();
      test_table();
      test_hold();
      test_sweep();
      test_midreset();
      test_random();
`ifdef BTOG_CHECK_EN
      test_check();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
